ch1_sweep_seq: RTL and testbench
================================

CH1_SWEEP_SEQ -- requirements
Module: ch1_sweep_seq

Interface
REQ-001 Parameter SETTLE_CYC, default 1: idle cycles between the last shift pulse and sampling atys (range 1..3).
REQ-002 clk  in  1  APU clock; all state changes on its rising edge.
REQ-003 napu_reset  in  1  reset, asynchronous, active-low.
REQ-004 d  in  8  CPU data bus.
REQ-005 apu_wr  in  1  APU register write strobe; one cycle per write.
REQ-006 ff10  in  1  NR10 select.
REQ-007 ff14  in  1  NR14 select; d[7]=1 on write is trigger.
REQ-008 sweep_tick  in  1  128 Hz frame-sequencer enable; one cycle high.
REQ-009 atys  in  1  adder no-overflow flag from ch1_sweep; 0 = overflow.
REQ-010 nff10_d3  out  1  inverted NR10 negate bit.
REQ-011 ch1_ld_shift  out  1  load pulse for the shadow/shift register.
REQ-012 ch1_shift_clk  out  1  single shift-step pulse.
REQ-013 ch1_freq_upd1, ch1_freq_upd2  out  1 each  frequency write-back pulses for high bits and low bits.
REQ-014 ch1_sweep_kill  out  1  channel-disable pulse.
REQ-015 sweep_busy  out  1  high whenever the FSM is not IDLE.

Function
REQ-016 NR10 write (apu_wr&&ff10): capture period=d[6:4], negate=d[3], shift=d[2:0]; d[7] is ignored; nff10_d3 = !negate, combinational from the register.
REQ-017 Pulse outputs are single-cycle and registered; no two pulse types are asserted in the same cycle, except upd1 and upd2, which always assert together.
REQ-018 Timer: 3-bit down-counter. Reload value = period, or 8 when period=0. Reload occurs on trigger and on expiry.
REQ-019 sweep_en is set on trigger when period!=0 or shift!=0, cleared otherwise; it is also cleared by kill.
REQ-020 On sweep_tick the timer decrements; on reaching 0 it reloads. If sweep_en=1, period!=0 and the FSM is IDLE, a tick sequence starts the next cycle. Expiry while busy is dropped.
REQ-021 On trigger with shift!=0, a trigger sequence (check only) starts the next cycle. With shift=0, no sequence starts.
REQ-022 FSM states: IDLE, LOAD, SHIFT, SETTLE, EVAL; plus a pass bit (0/1) and an origin bit (tick/trigger).
REQ-023 LOAD lasts 1 cycle: ld_shift=1; latch shift into a 3-bit shift count cnt.
REQ-024 SHIFT: if cnt!=0, emit shift_clk=1 and decrement cnt each cycle; when cnt=0, go to SETTLE. A shift value of n yields exactly n pulses on consecutive cycles.
REQ-025 SETTLE: wait SETTLE_CYC cycles, then go to EVAL.
REQ-026 EVAL (1 cycle), resolved in priority order:
  - atys=0: kill=1, sweep_en=0, go to IDLE.
  - pass=0, origin=tick, latched shift!=0: upd1=upd2=1, pass=1, go to LOAD (second overflow check, never writes back).
  - otherwise: go to IDLE.
REQ-027 Trigger while busy: abort the current sequence with no pulses in that cycle, reload the timer, and restart per REQ-021 from pass=0.
REQ-028 NR10 write mid-sequence: it does not alter the latched cnt, but applies from the next LOAD. A negate change is visible to the adder immediately.
REQ-029 Tick and trigger in the same cycle: trigger wins; the tick decrement is discarded.

Reset
REQ-030 napu_reset=0 forces, asynchronously: NR10=0 (so nff10_d3=1), timer=0, sweep_en=0, FSM=IDLE, pass=0, cnt=0, all pulse outputs=0, sweep_busy=0.
REQ-031 Reset asserted mid-sequence truncates it with no further pulses; after release the block waits in IDLE for a trigger.

Structure
REQ-032 The FSM state enum and the value 8 for the period-0 reload belong in the shared APU package.
REQ-033 The period timer is a sub-module, ch1_sweep_timer (reload, tick, expiry pulse); the FSM stays in ch1_sweep_seq.

Verification
REQ-034 NR10=0x11, trigger, atys=1:
  - ld_shift at cycle T+1, one shift_clk at T+2, no upd pulse;
  - after 1 tick: ld, 1 shift, upd1/upd2, ld, 1 shift, IDLE.
REQ-035 NR10=0x07, trigger, tick: 7 consecutive shift_clk pulses per pass; sweep_busy high for exactly 1+7+SETTLE_CYC+1 cycles on the trigger sequence.
REQ-036 NR10=0x21, trigger, tick, tick with atys held 0 at EVAL: kill on the trigger check, and every later tick produces no pulses.
REQ-037 NR10=0x01, trigger, 8 ticks: no tick sequence occurs (period 0); the timer wraps every 8 ticks.
REQ-038 Trigger asserted during SHIFT of a tick sequence: no upd pulse; a fresh ld_shift on the next cycle.
REQ-039 Reset pulsed during SHIFT: all outputs 0 within the same cycle; sweep_busy=0; nff10_d3=1.

Source files
------------

// File: rtl/ch1_sweep_seq_pkg.sv
// Shared APU constants for the channel-1 sweep sequencer: FSM encoding, sequence origin, timer reload.
// Pure declarations; no logic, no latency, no flow control.
package ch1_sweep_seq_pkg;

   typedef logic [2:0] sweep_state_t;

   localparam sweep_state_t ST_IDLE   = 3'd0;
   localparam sweep_state_t ST_LOAD   = 3'd1;
   localparam sweep_state_t ST_SHIFT  = 3'd2;
   localparam sweep_state_t ST_SETTLE = 3'd3;
   localparam sweep_state_t ST_EVAL   = 3'd4;

   localparam logic ORIG_TICK = 1'b0;
   localparam logic ORIG_TRIG = 1'b1;

   localparam logic [3:0] SWEEP_P0_RELOAD = 4'd8;

   // Value 8 truncates to 0 in the 3-bit timer, which then wraps through 7..1: eight ticks.
   function automatic logic [2:0] sweep_reload(input logic [2:0] period);
      return (period == 3'd0) ? SWEEP_P0_RELOAD[2:0] : period;
   endfunction

endpackage

// File: rtl/ch1_sweep_timer.sv
// Sweep period timer: 3-bit down-counter reloaded on trigger or expiry.
// expire is combinational in the tick cycle; reload beats tick; no backpressure.
module ch1_sweep_timer (
   input  logic       clk,
   input  logic       napu_reset,
   input  logic       reload,
   input  logic       tick,
   input  logic [2:0] period,
   output logic       expire
);
   import ch1_sweep_seq_pkg::*;

   logic [2:0] timer;

   assign expire = tick && !reload && (timer == 3'd1);

   always_ff @(posedge clk or negedge napu_reset) begin
      if (!napu_reset) begin
         timer <= 3'd0;
      end else if (reload) begin
         timer <= sweep_reload(period);
      end else if (tick) begin
         timer <= (timer == 3'd1) ? sweep_reload(period) : timer - 3'd1;
      end
   end

endmodule

// File: rtl/ch1_sweep_seq.sv
// Channel-1 frequency sweep sequencer: NR10 register, period timer and load/shift/settle/eval FSM.
// Pulses are registered, one cycle after the deciding edge; trigger aborts any sequence; no backpressure.
module ch1_sweep_seq #(
   parameter int SETTLE_CYC = 1
) (
   input  logic       clk,
   input  logic       napu_reset,
   input  logic [7:0] d,
   input  logic       apu_wr,
   input  logic       ff10,
   input  logic       ff14,
   input  logic       sweep_tick,
   input  logic       atys,
   output logic       nff10_d3,
   output logic       ch1_ld_shift,
   output logic       ch1_shift_clk,
   output logic       ch1_freq_upd1,
   output logic       ch1_freq_upd2,
   output logic       ch1_sweep_kill,
   output logic       sweep_busy
);
   import ch1_sweep_seq_pkg::*;

   localparam logic [1:0] SETTLE_INIT = 2'(SETTLE_CYC - 1);

   logic [2:0]   nr10_period, nr10_shift;
   logic         nr10_negate;
   sweep_state_t state, nxt_state;
   logic [2:0]   cnt, nxt_cnt, shift_lat, nxt_shift_lat;
   logic [1:0]   settle, nxt_settle;
   logic         pass, nxt_pass, origin, nxt_origin, sweep_en, nxt_en;
   logic         nxt_ld, nxt_sclk, nxt_upd, nxt_kill, upd_q;
   logic         nr10_wr, trig, expire;

   assign nr10_wr       = apu_wr && ff10;
   assign trig          = apu_wr && ff14 && d[7];
   assign nff10_d3      = !nr10_negate;
   assign sweep_busy    = (state != ST_IDLE);
   assign ch1_freq_upd1 = upd_q;
   assign ch1_freq_upd2 = upd_q;

   ch1_sweep_timer u_timer (
      .clk        (clk),
      .napu_reset (napu_reset),
      .reload     (trig),
      .tick       (sweep_tick),
      .period     (nr10_period),
      .expire     (expire)
   );

   always_ff @(posedge clk or negedge napu_reset) begin
      if (!napu_reset) begin
         nr10_period <= 3'd0;
         nr10_negate <= 1'b0;
         nr10_shift  <= 3'd0;
      end else if (nr10_wr) begin
         nr10_period <= d[6:4];
         nr10_negate <= d[3];
         nr10_shift  <= d[2:0];
      end
   end

   always_comb begin
      nxt_state     = state;
      nxt_cnt       = cnt;
      nxt_settle    = settle;
      nxt_pass      = pass;
      nxt_origin    = origin;
      nxt_shift_lat = shift_lat;
      nxt_en        = sweep_en;
      nxt_ld        = 1'b0;
      nxt_sclk      = 1'b0;
      nxt_upd       = 1'b0;
      nxt_kill      = 1'b0;
      if (trig) begin
         nxt_en     = (nr10_period != 3'd0) || (nr10_shift != 3'd0);
         nxt_pass   = 1'b0;
         nxt_origin = ORIG_TRIG;
         if (nr10_shift != 3'd0) begin
            nxt_state = ST_LOAD;
            nxt_ld    = 1'b1;
         end else begin
            nxt_state = ST_IDLE;
         end
      end else begin
         case (state)
            ST_IDLE: begin
               if (expire && sweep_en && (nr10_period != 3'd0)) begin
                  nxt_state  = ST_LOAD;
                  nxt_ld     = 1'b1;
                  nxt_pass   = 1'b0;
                  nxt_origin = ORIG_TICK;
               end
            end
            ST_LOAD: begin
               nxt_cnt       = nr10_shift;
               nxt_shift_lat = nr10_shift;
               if (nr10_shift != 3'd0) begin
                  nxt_state = ST_SHIFT;
                  nxt_sclk  = 1'b1;
               end else begin
                  nxt_state  = ST_SETTLE;
                  nxt_settle = SETTLE_INIT;
               end
            end
            ST_SHIFT: begin
               // cnt counts the pulse on the output this cycle, so 1 means it was the last one.
               if (cnt > 3'd1) begin
                  nxt_cnt  = cnt - 3'd1;
                  nxt_sclk = 1'b1;
               end else begin
                  nxt_cnt    = 3'd0;
                  nxt_state  = ST_SETTLE;
                  nxt_settle = SETTLE_INIT;
               end
            end
            ST_SETTLE: begin
               if (settle != 2'd0) begin
                  nxt_settle = settle - 2'd1;
               end else begin
                  nxt_state = ST_EVAL;
                  if (!atys) begin
                     nxt_kill = 1'b1;
                     nxt_en   = 1'b0;
                  end else if (!pass && (origin == ORIG_TICK) && (shift_lat != 3'd0)) begin
                     nxt_upd = 1'b1;
                  end
               end
            end
            ST_EVAL: begin
               if (upd_q) begin
                  nxt_state = ST_LOAD;
                  nxt_ld    = 1'b1;
                  nxt_pass  = 1'b1;
               end else begin
                  nxt_state = ST_IDLE;
                  nxt_pass  = 1'b0;
               end
            end
            default: nxt_state = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge napu_reset) begin
      if (!napu_reset) begin
         state          <= ST_IDLE;
         cnt            <= 3'd0;
         settle         <= 2'd0;
         pass           <= 1'b0;
         origin         <= ORIG_TICK;
         shift_lat      <= 3'd0;
         sweep_en       <= 1'b0;
         ch1_ld_shift   <= 1'b0;
         ch1_shift_clk  <= 1'b0;
         upd_q          <= 1'b0;
         ch1_sweep_kill <= 1'b0;
      end else begin
         state          <= nxt_state;
         cnt            <= nxt_cnt;
         settle         <= nxt_settle;
         pass           <= nxt_pass;
         origin         <= nxt_origin;
         shift_lat      <= nxt_shift_lat;
         sweep_en       <= nxt_en;
         ch1_ld_shift   <= nxt_ld;
         ch1_shift_clk  <= nxt_sclk;
         upd_q          <= nxt_upd;
         ch1_sweep_kill <= nxt_kill;
      end
   end

endmodule

// File: tb/tb_ch1_sweep_seq.sv
// Directed bench for ch1_sweep_seq: vector table plus hand sequences for multi-cycle corners.
module tb_ch1_sweep_seq;
   localparam int S = 1;

   // Expected output bits: {ld_shift, shift_clk, upd, kill, busy, nff10_d3}
   localparam logic [5:0] IN = 6'b000001;
   localparam logic [5:0] LD = 6'b100011;
   localparam logic [5:0] SC = 6'b010011;
   localparam logic [5:0] BZ = 6'b000011;
   localparam logic [5:0] UP = 6'b001011;
   localparam logic [5:0] KL = 6'b000111;

   logic       clk = 1'b0;
   logic       napu_reset;
   logic [7:0] d;
   logic       apu_wr, ff10, ff14, sweep_tick, atys;
   logic       nff10_d3, ch1_ld_shift, ch1_shift_clk, ch1_freq_upd1, ch1_freq_upd2;
   logic       ch1_sweep_kill, sweep_busy;

   typedef struct {
      logic       w10;
      logic       w14;
      logic [7:0] dat;
      logic       tick;
      logic       atys;
      logic [5:0] exp;
   } vec_t;

   vec_t tab[$];
   int   total = 0;
   int   bad = 0;
   int   nb, ns, nu, first, last;
   logic cur_atys, act;

   always #5 clk = ~clk;

   ch1_sweep_seq #(.SETTLE_CYC(S)) dut (
      .clk            (clk),
      .napu_reset     (napu_reset),
      .d              (d),
      .apu_wr         (apu_wr),
      .ff10           (ff10),
      .ff14           (ff14),
      .sweep_tick     (sweep_tick),
      .atys           (atys),
      .nff10_d3       (nff10_d3),
      .ch1_ld_shift   (ch1_ld_shift),
      .ch1_shift_clk  (ch1_shift_clk),
      .ch1_freq_upd1  (ch1_freq_upd1),
      .ch1_freq_upd2  (ch1_freq_upd2),
      .ch1_sweep_kill (ch1_sweep_kill),
      .sweep_busy     (sweep_busy)
   );

   function automatic logic [6:0] outs();
      return {ch1_ld_shift, ch1_shift_clk, ch1_freq_upd1, ch1_freq_upd2,
              ch1_sweep_kill, sweep_busy, nff10_d3};
   endfunction

   function automatic logic [6:0] expand(input logic [5:0] e);
      return {e[5], e[4], e[3], e[3], e[2], e[1], e[0]};
   endfunction

   task automatic add(input logic w10, input logic w14, input logic [7:0] dat,
                      input logic tk, input logic [5:0] e);
      vec_t v;
      v.w10 = w10; v.w14 = w14; v.dat = dat; v.tick = tk; v.atys = cur_atys; v.exp = e;
      tab.push_back(v);
   endtask

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, got, want);
      end
   endtask

   // Called at a negedge: drives for one cycle, returns at the next negedge with inputs cleared.
   task automatic step(input logic w10, input logic w14, input logic [7:0] dat, input logic tk);
      apu_wr = w10 || w14; ff10 = w10; ff14 = w14; d = dat; sweep_tick = tk;
      @(negedge clk);
      apu_wr = 1'b0; ff10 = 1'b0; ff14 = 1'b0; d = 8'h00; sweep_tick = 1'b0;
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 8'h00, 1'b0);
   endtask

   task automatic drain(input string nm);
      for (int c = 0; c < 40 && sweep_busy; c++) idle();
      chk(nm, sweep_busy, 1'b0);
   endtask

   task automatic count_seq();
      nb = 0; ns = 0; nu = 0; first = -1; last = -1;
      for (int c = 0; c < 60 && sweep_busy; c++) begin
         nb++;
         if (ch1_freq_upd1) nu++;
         if (ch1_shift_clk) begin
            ns++;
            if (first < 0) first = c;
            last = c;
         end
         idle();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      napu_reset = 1'b0; apu_wr = 1'b0; ff10 = 1'b0; ff14 = 1'b0; d = 8'h00;
      sweep_tick = 1'b0; atys = 1'b1;
      #3;
      chk("reset_outs", outs(), 7'b0000001);
      @(negedge clk); @(negedge clk);
      napu_reset = 1'b1;
      @(negedge clk);

      // Basic trigger check and tick sequence with write-back
      cur_atys = 1'b1;
      add(1, 0, 8'h11, 0, IN); add(0, 1, 8'h80, 0, LD);
      add(0, 0, 8'h00, 0, SC); add(0, 0, 8'h00, 0, BZ); add(0, 0, 8'h00, 0, BZ);
      add(0, 0, 8'h00, 0, IN);
      add(0, 0, 8'h00, 1, LD); add(0, 0, 8'h00, 0, SC); add(0, 0, 8'h00, 0, BZ);
      add(0, 0, 8'h00, 0, UP); add(0, 0, 8'h00, 0, LD); add(0, 0, 8'h00, 0, SC);
      add(0, 0, 8'h00, 0, BZ); add(0, 0, 8'h00, 0, BZ); add(0, 0, 8'h00, 0, IN);
      // Negate bit, d[7] ignored on NR10, trigger with period 0 and shift 0
      add(1, 0, 8'h08, 0, 6'b000000); add(1, 0, 8'h80, 0, IN);
      add(0, 1, 8'h80, 0, IN); add(0, 0, 8'h00, 1, IN);
      // Trigger and tick together: tick discarded, period-2 timer needs two more ticks
      add(1, 0, 8'h21, 0, IN); add(0, 1, 8'h80, 1, LD);
      add(0, 0, 8'h00, 0, SC); add(0, 0, 8'h00, 0, BZ); add(0, 0, 8'h00, 0, BZ);
      add(0, 0, 8'h00, 0, IN); add(0, 0, 8'h00, 1, IN); add(0, 0, 8'h00, 1, LD);
      add(0, 0, 8'h00, 0, SC); add(0, 0, 8'h00, 0, BZ); add(0, 0, 8'h00, 0, UP);
      add(0, 0, 8'h00, 0, LD); add(0, 0, 8'h00, 0, SC); add(0, 0, 8'h00, 0, BZ);
      add(0, 0, 8'h00, 0, BZ); add(0, 0, 8'h00, 0, IN);
      // NR10 rewrite mid-SHIFT keeps the latched count, negate flips at once
      add(1, 0, 8'h13, 0, IN); add(0, 1, 8'h80, 0, LD); add(0, 0, 8'h00, 0, SC);
      add(1, 0, 8'h19, 0, 6'b010010); add(0, 0, 8'h00, 0, 6'b010010);
      add(0, 0, 8'h00, 0, 6'b000010); add(0, 0, 8'h00, 0, 6'b000010);
      add(0, 0, 8'h00, 0, 6'b000000); add(1, 0, 8'h00, 0, IN);
      // Overflow on the trigger check kills the channel; later ticks stay silent
      cur_atys = 1'b0;
      add(1, 0, 8'h21, 0, IN); add(0, 1, 8'h80, 0, LD);
      add(0, 0, 8'h00, 0, SC); add(0, 0, 8'h00, 0, BZ); add(0, 0, 8'h00, 0, KL);
      add(0, 0, 8'h00, 0, IN);
      for (int k = 0; k < 4; k++) add(0, 0, 8'h00, 1, IN);
      // Period 0: trigger check only, ticks never start a sequence
      cur_atys = 1'b1;
      add(1, 0, 8'h01, 0, IN); add(0, 1, 8'h80, 0, LD);
      add(0, 0, 8'h00, 0, SC); add(0, 0, 8'h00, 0, BZ); add(0, 0, 8'h00, 0, BZ);
      add(0, 0, 8'h00, 0, IN);
      for (int k = 0; k < 9; k++) add(0, 0, 8'h00, 1, IN);

      foreach (tab[i]) begin
         atys = tab[i].atys;
         step(tab[i].w10, tab[i].w14, tab[i].dat, tab[i].tick);
         chk($sformatf("vec%0d", i), outs(), expand(tab[i].exp));
      end
      atys = 1'b1;

      // Seven-step shift: busy length and consecutive pulses
      step(1, 0, 8'h07, 0);
      step(0, 1, 8'h80, 0);
      count_seq();
      chk("trig_busy_len", nb, 1 + 7 + S + 1);
      chk("trig_shift_cnt", ns, 7);
      chk("trig_shift_run", last - first + 1, 7);
      chk("trig_no_upd", nu, 0);

      step(1, 0, 8'h17, 0);
      step(0, 1, 8'h80, 0);
      drain("drain_17");
      step(0, 0, 8'h00, 1);
      count_seq();
      chk("tick_busy_len", nb, 2 * (1 + 7 + S + 1));
      chk("tick_shift_cnt", ns, 14);
      chk("tick_upd_cnt", nu, 1);

      // Trigger during SHIFT of a tick sequence
      step(1, 0, 8'h13, 0);
      step(0, 1, 8'h80, 0);
      drain("drain_13");
      step(0, 0, 8'h00, 1);
      chk("abort_tick_ld", ch1_ld_shift, 1'b1);
      idle();
      chk("abort_in_shift", ch1_shift_clk, 1'b1);
      step(0, 1, 8'h80, 0);
      chk("abort_fresh_ld", {ch1_ld_shift, ch1_shift_clk, ch1_freq_upd1}, 3'b100);
      count_seq();
      chk("abort_no_upd", nu, 0);
      chk("abort_shift_cnt", ns, 3);

      // Asynchronous reset in the middle of SHIFT
      step(1, 0, 8'h1F, 0);
      chk("neg_before_rst", nff10_d3, 1'b0);
      step(0, 1, 8'h80, 0);
      idle();
      chk("shift_before_rst", ch1_shift_clk, 1'b1);
      #2 napu_reset = 1'b0;
      #1 chk("rst_async_outs", outs(), 7'b0000001);
      @(negedge clk); @(negedge clk);
      napu_reset = 1'b1;
      act = 1'b0;
      for (int k = 0; k < 20; k++) begin
         step(0, 0, 8'h00, 1);
         act = act | ch1_ld_shift | ch1_shift_clk | ch1_freq_upd1 | ch1_sweep_kill | sweep_busy;
      end
      chk("post_rst_quiet", act, 1'b0);
      chk("post_rst_nff", nff10_d3, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
